serial_mem_bridge: RTL
======================

# serial_mem_bridge

Byte-command bridge between the RS232 UART and the Processor's external memory port. It parses host commands arriving on the RX byte stream and performs word writes or reads through the external memory control lines. It also controls the processor `pause` line and returns acknowledge or read-data bytes on the TX stream. Address and data widths are set by parameters; it sits in Main between `RS232` and `Processor`.

## Interface

- `ADDR_BYTES`, default 4: address bytes per command, sent MSB first; address width is 8*ADDR_BYTES, at most 32.
- `DATA_BYTES`, default 4: data bytes per write or read, MSB first; data width is 8*DATA_BYTES, at most 32.
- `WRITE_MODE`, default 3'd3: value driven on `externalWriteMode` during a write cycle.
- `READ_MODE`, default 3'd3: value driven on `externalReadMode` during a read.
- `READ_LATENCY`, default 1: cycles from read request until `externalDataOut` is valid; must be at least 1.
- `TIMEOUT_CYCLES`, default 250000: maximum idle gap between bytes of one command.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `RX` in 8: received byte, valid while `hasRX` is high.
- `hasRX` in 1: one-cycle pulse, one byte available.
- `rxError` in 1: UART framing error pulse.
- `TX_ready` in 1: UART can accept a byte.
- `TX` out 8: byte to transmit.
- `start_TX` out 1: one-cycle transmit strobe.
- `pause` out 1: processor halt.
- `externalMemoryControl` out 1: bridge owns the memory port.
- `externalAddress` out 32: zero-extended address.
- `externalData` out 32: zero-extended write data.
- `externalWriteMode` out 3: 0 means no write.
- `externalReadMode` out 3: 0 means no read.
- `externalDataOut` in 32: read data; low 8*DATA_BYTES bits are used.

## Operation

- Opcodes:
  - 0x57 `W`: followed by address bytes, then data bytes. Performs a write, then replies ACK 0x06.
  - 0x52 `R`: followed by address bytes. Performs a read, then replies with DATA_BYTES bytes, MSB first.
  - 0x50 `P`: sets the pause latch, replies ACK.
  - 0x47 `G`: clears the pause latch, replies ACK.
  - Any other byte: replies NAK 0x15.
- States and transitions:
  - IDLE: waits for an opcode.
  - ADDR: shifts address bytes left into the address register (byte counter 0..ADDR_BYTES-1).
  - DATA: shifts data bytes the same way.
  - MEM_WR: lasts exactly 1 cycle.
  - MEM_RD: holds for READ_LATENCY cycles, then captures `externalDataOut` into the shift register.
  - TX_LOAD, TX_WAIT: send the reply bytes, then return to IDLE.
- `pause` = pause latch OR (state is MEM_WR or MEM_RD). The processor is halted during every access regardless of the latch.
- `externalMemoryControl` is 1 only in MEM_WR or MEM_RD.
  - Write and read modes are nonzero only in their own state; otherwise both are 0.
  - Address and data are held stable throughout the access.
- `hasRX` outside IDLE, ADDR or DATA: the byte is dropped with no reply.
- Gap timeout: a counter clears on every byte. If it reaches TIMEOUT_CYCLES while in ADDR or DATA, go to IDLE with no reply and no memory access.
- `rxError` while in IDLE, ADDR or DATA: abort the command and reply one NAK. `rxError` in any other state is ignored.
- A `hasRX` pulse and a timeout in the same cycle: the byte wins and the counter clears.

## Timing

- Reset values:
  - All outputs 0: `TX`, `start_TX`, `pause`, control, address, data and both modes.
  - Pause latch cleared, state IDLE, all counters 0.
- The final command byte accepted at edge N gives the following:
  - Write: MEM_WR is active in cycle N+1.
  - Read: MEM_RD spans cycles N+1 to N+READ_LATENCY, with data captured at the end of its last cycle.
  - P, G or unknown opcode: the pause latch updates at edge N, and TX_LOAD is entered at N+1.
- TX handshake:
  - In TX_LOAD, `start_TX` pulses for exactly one cycle, only when `TX_ready` is 1. `TX` holds the byte in that cycle and stays stable until the next load.
  - TX_WAIT ignores `TX_ready` for 2 cycles, then waits for `TX_ready`=1.
  - It then loads the next byte or returns to IDLE.
- Reset mid-operation aborts any transfer immediately. The current access or reply is lost and `pause` drops.

## Test plan

- Write: bytes 57 00 00 01 00 DE AD BE EF → exactly one cycle with control=1, writeMode=3, addr 0x00000100, data 0xDEADBEEF and pause=1. Then TX 0x06.
- Read: bytes 52 00 00 01 00, with the model returning 0xCAFEF00D after 1 cycle → readMode=3 for 1 cycle, then TX CA, FE, F0, 0D in order with one `start_TX` each.
- Pause: byte 50 → `pause`=1 persists plus ACK. Then byte 47 → `pause`=0 plus ACK. Also a write with the latch clear shows `pause` high only in MEM_WR.
- Unknown byte 0x33 → NAK 0x15, no memory activity. `rxError` during ADDR → one NAK, back to IDLE.
- Timeout (TIMEOUT_CYCLES=100): bytes 57 00 then 101 idle cycles → no TX and no access. A following byte 50 is handled normally.
- Reset: assert `rst` after the second read-reply byte → all outputs 0 asynchronously, and no further `start_TX`.

Source files
------------

// File: rtl/serial_mem_bridge_if.sv
// Bus bundle between serial_mem_bridge and its UART / processor neighbours.
// The master side is the bridge and the slave side is the environment, meaning the UART and the memory port.
interface serial_mem_bridge_if;
    logic [7:0]  RX;
    logic        hasRX;
    logic        rxError;
    logic        TX_ready;
    logic [7:0]  TX;
    logic        start_TX;
    logic        pause;
    logic        externalMemoryControl;
    logic [31:0] externalAddress;
    logic [31:0] externalData;
    logic [2:0]  externalWriteMode;
    logic [2:0]  externalReadMode;
    logic [31:0] externalDataOut;

    modport master (
        input  RX, hasRX, rxError, TX_ready, externalDataOut,
        output TX, start_TX, pause, externalMemoryControl,
               externalAddress, externalData, externalWriteMode, externalReadMode
    );

    modport slave (
        output RX, hasRX, rxError, TX_ready, externalDataOut,
        input  TX, start_TX, pause, externalMemoryControl,
               externalAddress, externalData, externalWriteMode, externalReadMode
    );
endinterface

// File: rtl/serial_mem_bridge.sv
// Parses host byte commands (W/R/P/G) from the UART and performs word accesses on the
// processor's external memory port, replying with ACK/NAK or read-data bytes.
module serial_mem_bridge #(
    parameter int       ADDR_BYTES     = 4,
    parameter int       DATA_BYTES     = 4,
    parameter logic [2:0] WRITE_MODE   = 3'd3,
    parameter logic [2:0] READ_MODE    = 3'd3,
    parameter int       READ_LATENCY   = 1,
    parameter int       TIMEOUT_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              rst,
    serial_mem_bridge_if.master bus
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam logic [31:0] AMASK = 32'((64'd1 << AW) - 64'd1);
    localparam logic [31:0] DMASK = 32'((64'd1 << DW) - 64'd1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(READ_LATENCY + 1);

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_P = 8'h50;
    localparam logic [7:0] OP_G = 8'h47;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_MEM_WR, S_MEM_RD, S_TX_LOAD, S_TX_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]  tx_left_q, tx_left_d;
    logic        is_write_q, is_write_d;
    logic        latch_q, latch_d;
    logic [7:0]  tx_q, tx_d;
    logic        pause_q, pause_d;
    logic        ctrl_q, ctrl_d;
    logic [2:0]  wmode_q, wmode_d;
    logic [2:0]  rmode_q, rmode_d;
    logic        reply_now;
    logic [7:0]  reply_byte;
    logic        in_mem;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        byte_cnt_d = byte_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        tmo_cnt_d  = '0;
        wait_cnt_d = wait_cnt_q;
        tx_left_d  = tx_left_q;
        is_write_d = is_write_q;
        latch_d    = latch_q;
        tx_d       = tx_q;
        reply_now  = 1'b0;
        reply_byte = ACK;

        unique case (state_q)
            S_IDLE: begin
                if (bus.rxError) begin
                    reply_now  = 1'b1;
                    reply_byte = NAK;
                end else if (bus.hasRX) begin
                    unique case (bus.RX)
                        OP_W, OP_R: begin
                            state_d    = S_ADDR;
                            is_write_d = (bus.RX == OP_W);
                            addr_d     = '0;
                            byte_cnt_d = '0;
                        end
                        OP_P: begin latch_d = 1'b1; reply_now = 1'b1; end
                        OP_G: begin latch_d = 1'b0; reply_now = 1'b1; end
                        default: begin reply_now = 1'b1; reply_byte = NAK; end
                    endcase
                end
            end
            S_ADDR, S_DATA: begin
                if (bus.rxError) begin
                    reply_now  = 1'b1;
                    reply_byte = NAK;
                end else if (bus.hasRX) begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (state_q == S_ADDR) begin
                        addr_d = {addr_q[23:0], bus.RX} & AMASK;
                        if (byte_cnt_q == 3'(ADDR_BYTES - 1)) begin
                            byte_cnt_d = '0;
                            lat_cnt_d  = '0;
                            data_d     = is_write_q ? 32'h0 : data_q;
                            state_d    = is_write_q ? S_DATA : S_MEM_RD;
                        end
                    end else begin
                        data_d = {data_q[23:0], bus.RX} & DMASK;
                        if (byte_cnt_q == 3'(DATA_BYTES - 1)) begin
                            byte_cnt_d = '0;
                            state_d    = S_MEM_WR;
                        end
                    end
                end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Gap too long: drop the partial command silently.
                    state_d    = S_IDLE;
                    byte_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            S_MEM_WR: reply_now = 1'b1;
            S_MEM_RD: begin
                if (lat_cnt_q == LW'(READ_LATENCY - 1)) begin
                    data_d    = bus.externalDataOut & DMASK;
                    state_d   = S_TX_LOAD;
                    tx_d      = data_d[DW-1 -: 8];
                    tx_left_d = 3'(DATA_BYTES);
                end else begin
                    lat_cnt_d = lat_cnt_q + LW'(1);
                end
            end
            S_TX_LOAD: begin
                if (bus.TX_ready) begin
                    state_d    = S_TX_WAIT;
                    wait_cnt_d = '0;
                    tx_left_d  = tx_left_q - 3'd1;
                    data_d     = (data_q << 8) & DMASK;
                end
            end
            S_TX_WAIT: begin
                // The UART may still report ready right after the strobe, so skip two cycles.
                if (wait_cnt_q != 2'd2) begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end else if (bus.TX_ready) begin
                    if (tx_left_q != 3'd0) begin
                        state_d = S_TX_LOAD;
                        tx_d    = data_q[DW-1 -: 8];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (reply_now) begin
            state_d   = S_TX_LOAD;
            tx_d      = reply_byte;
            tx_left_d = 3'd1;
        end

        in_mem  = (state_d == S_MEM_WR) || (state_d == S_MEM_RD);
        pause_d = latch_d | in_mem;
        ctrl_d  = in_mem;
        wmode_d = (state_d == S_MEM_WR) ? WRITE_MODE : 3'd0;
        rmode_d = (state_d == S_MEM_RD) ? READ_MODE  : 3'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            byte_cnt_q <= '0;
            lat_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            wait_cnt_q <= '0;
            tx_left_q  <= '0;
            is_write_q <= 1'b0;
            latch_q    <= 1'b0;
            tx_q       <= '0;
            pause_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            wmode_q    <= '0;
            rmode_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            byte_cnt_q <= byte_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            tx_left_q  <= tx_left_d;
            is_write_q <= is_write_d;
            latch_q    <= latch_d;
            tx_q       <= tx_d;
            pause_q    <= pause_d;
            ctrl_q     <= ctrl_d;
            wmode_q    <= wmode_d;
            rmode_q    <= rmode_d;
        end
    end

    assign bus.TX                    = tx_q;
    assign bus.start_TX              = (state_q == S_TX_LOAD) && bus.TX_ready;
    assign bus.pause                 = pause_q;
    assign bus.externalMemoryControl = ctrl_q;
    assign bus.externalAddress       = addr_q;
    assign bus.externalData          = data_q;
    assign bus.externalWriteMode     = wmode_q;
    assign bus.externalReadMode      = rmode_q;
endmodule
